// File: rtl/mult_share_arbiter_if.sv
// Requester/result handshake bundle between the FP front ends and the shared-multiplier arbiter.
// The master side issues operand requests and consumes results; the slave side is the arbiter.
interface mult_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*25-1:0] req_x;
    logic [N_REQ*25-1:0] req_y;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic [47:0]         res_data;
    logic [ID_W-1:0]     res_id;
    logic                res_err;
    logic                res_ready;

    modport master (
        output req_valid, req_x, req_y, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err
    );

    modport slave (
        input  req_valid, req_x, req_y, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one iterative 24x24 Booth mantissa multiplier between N_REQ requesters,
// with operand hand-off, multiplier sequencing through its reset, result return and a timeout watchdog.
//
// state | meaning
// IDLE  | multiplier parked in reset, waiting for any req_valid
// RUN   | multiplier released, operands held, waiting for mul_ready or timeout
// RESP  | result (or timeout error) presented until res_ready
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mult_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic                 mul_rst,
    output logic [24:0]          mul_x,
    output logic [24:0]          mul_y,
    input  logic [47:0]          mul_out,
    input  logic                 mul_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      cnt;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;
    logic [24:0]     grant_x;
    logic [24:0]     grant_y;

    // First asserted request at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_x = '0;
        grant_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_x = bus.req_x[25*i +: 25];
                grant_y = bus.req_y[25*i +: 25];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cnt           <= '0;
            mul_rst       <= 1'b1;
            mul_x         <= '0;
            mul_y         <= '0;
            busy          <= 1'b0;
            bus.req_ready <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.req_ready <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
                        mul_x         <= grant_x;
                        mul_y         <= grant_y;
                        bus.res_id    <= grant_idx;
                        rr_ptr        <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                        mul_rst       <= 1'b0;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 8'd1;
                    // A ready arriving on the timeout cycle still delivers the product.
                    if (mul_ready) begin
                        bus.res_data  <= mul_out;
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        mul_rst       <= 1'b1;
                        state         <= RESP;
                    end else if (cnt == 8'(TIMEOUT-1)) begin
                        bus.res_data  <= '0;
                        bus.res_err   <= 1'b1;
                        bus.res_valid <= 1'b1;
                        mul_rst       <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.res_err   <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier with programmable latency, directed scenarios
// and a randomized round-robin run checked against a request-queue reference model.
module tb_mult_share_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TMO = 31;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus ();

    logic        busy, mul_rst;
    logic [24:0] mul_x, mul_y;
    logic [47:0] mul_out = '0;
    logic        mul_ready = 1'b0;

    mult_share_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave), .busy(busy), .mul_rst(mul_rst),
        .mul_x(mul_x), .mul_y(mul_y), .mul_out(mul_out), .mul_ready(mul_ready)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_ptr = 0;

    function automatic logic [47:0] ref_prod(input logic [24:0] a, input logic [24:0] b);
        logic signed [49:0] p;
        p = $signed(a) * $signed(b);
        return p[47:0];
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Multiplier stand-in: ready L cycles after its reset is released.
    int m_lat = 14;
    bit m_never = 1'b0;
    int m_cnt = 0;
    always @(posedge clk) begin
        if (mul_rst) begin
            m_cnt     <= 0;
            mul_ready <= 1'b0;
            mul_out   <= '0;
        end else begin
            m_cnt <= m_cnt + 1;
            if (!m_never && (m_cnt + 1 == m_lat)) begin
                mul_ready <= 1'b1;
                mul_out   <= ref_prod(mul_x, mul_y);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [24:0] x, input logic [24:0] y);
        bus.req_valid[id]     = 1'b1;
        bus.req_x[25*id +: 25] = x;
        bus.req_y[25*id +: 25] = y;
    endtask

    // Drives one operation through and reports what was observed (no judging here).
    task automatic run_op(input int id, input logic [24:0] x, input logic [24:0] y, input bit drop,
                          input int hold_resp, output int acc, output int lat, output int rst_low,
                          output logic [47:0] data, output logic [IDW-1:0] rid, output logic err,
                          output logic [N-1:0] rdy_next, output logic [1:0] post);
        int n;
        if (id >= 0) set_req(id, x, y);
        n = 0;
        while (bus.req_ready == '0 && n < 60) begin step(); n++; end
        acc = -1;
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i]) acc = (acc == -1) ? i : -2;
        if (drop && acc >= 0) bus.req_valid[acc] = 1'b0;
        rst_low  = mul_rst ? 0 : 1;
        rdy_next = 'x;
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            step();
            lat++;
            if (lat == 1) rdy_next = bus.req_ready;
            if (!mul_rst) rst_low++;
        end
        data = bus.res_data;
        rid  = bus.res_id;
        err  = bus.res_err;
        repeat (hold_resp) step();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        post = {bus.res_valid, busy};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        vectors++;
        if ({bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_err, busy, mul_rst, mul_x, mul_y}
            !== {4'b0, 1'b0, 48'b0, 2'b0, 1'b0, 1'b0, 1'b1, 25'b0, 25'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%h id=%0d err=%b busy=%b mrst=%b x=%h y=%h",
                     bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_err, busy, mul_rst, mul_x, mul_y);
        end
        reset_n = 1'b1;
        repeat (3) step();
        vectors++;
        if ({busy, mul_rst, bus.req_ready} !== {1'b0, 1'b1, 4'b0}) begin
            miscompares++;
            $display("FAIL idle_hold: got busy=%b mrst=%b rdy=%b expected 0 1 0000", busy, mul_rst, bus.req_ready);
        end
        exp_ptr = 0;
    endtask

    task automatic test_basic();
        int acc, lat, rl; logic [47:0] d; logic [IDW-1:0] rid; logic e; logic [N-1:0] rn; logic [1:0] post;
        m_lat = 14;
        run_op(0, 25'd3, 25'd5, 1'b1, 0, acc, lat, rl, d, rid, e, rn, post);
        vectors++; if (acc !== 0)        begin miscompares++; $display("FAIL basic_grant: got %0d expected 0", acc); end
        vectors++; if (rn !== 4'b0)      begin miscompares++; $display("FAIL basic_pulse_len: got %b expected 0000", rn); end
        vectors++; if (rl !== 15)        begin miscompares++; $display("FAIL basic_mulrst_low: got %0d expected 15", rl); end
        vectors++; if (lat !== 15)       begin miscompares++; $display("FAIL basic_latency: got %0d expected 15", lat); end
        vectors++; if ({d, rid, e} !== {48'd15, 2'd0, 1'b0}) begin
            miscompares++; $display("FAIL basic_result: got data=%h id=%0d err=%b expected 15 0 0", d, rid, e); end
        vectors++; if (post !== 2'b00)   begin miscompares++; $display("FAIL basic_release: got vld,busy=%b expected 00", post); end
        exp_ptr = 1;
    endtask

    task automatic test_negative();
        int acc, lat, rl; logic [47:0] d; logic [IDW-1:0] rid; logic e; logic [N-1:0] rn; logic [1:0] post;
        run_op(2, 25'h1FFFFFE, 25'd7, 1'b1, 1, acc, lat, rl, d, rid, e, rn, post);
        vectors++; if (acc !== 2) begin miscompares++; $display("FAIL neg_grant: got %0d expected 2", acc); end
        vectors++; if ({d, rid, e} !== {48'hFFFF_FFFF_FFF2, 2'd2, 1'b0}) begin
            miscompares++; $display("FAIL neg_result: got data=%h id=%0d err=%b expected fffffffffff2 2 0", d, rid, e); end
        exp_ptr = 3;
    endtask

    task automatic test_rr_order();
        int acc, lat, rl, g; logic [47:0] d; logic [IDW-1:0] rid; logic e; logic [N-1:0] rn; logic [1:0] post;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        exp_ptr = 0;
        for (int i = 0; i < N; i++) set_req(i, 25'(i + 1), 25'(i + 100));
        for (int r = 0; r < 5; r++) begin
            g = exp_grant(4'hF, exp_ptr);
            run_op(-1, '0, '0, 1'b0, 0, acc, lat, rl, d, rid, e, rn, post);
            vectors++;
            if (acc !== g || d !== ref_prod(25'(g + 1), 25'(g + 100)) || rid !== IDW'(g)) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got grant=%0d data=%h id=%0d expected grant=%0d data=%h",
                         r, acc, d, rid, g, ref_prod(25'(g + 1), 25'(g + 100)));
            end
            exp_ptr = (g + 1) % N;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_timeout();
        int acc, lat, rl; logic [47:0] d; logic [IDW-1:0] rid; logic e; logic [N-1:0] rn; logic [1:0] post;
        m_never = 1'b1;
        run_op(1, 25'd9, 25'd9, 1'b1, 0, acc, lat, rl, d, rid, e, rn, post);
        m_never = 1'b0;
        vectors++; if (lat !== TMO) begin miscompares++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TMO); end
        vectors++; if ({d, rid, e} !== {48'd0, 2'd1, 1'b1}) begin
            miscompares++; $display("FAIL timeout_result: got data=%h id=%0d err=%b expected 0 1 1", d, rid, e); end
        vectors++; if (post !== 2'b00) begin miscompares++; $display("FAIL timeout_release: got vld,busy=%b expected 00", post); end
        exp_ptr = 2;
    endtask

    task automatic test_backpressure();
        int n;
        set_req(0, 25'd11, 25'd13);
        n = 0; while (bus.req_ready == '0 && n < 60) begin step(); n++; end
        vectors++; if (bus.req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL bp_grant0: got %b expected 0001", bus.req_ready); end
        bus.req_valid[0] = 1'b0;
        set_req(1, 25'd21, 25'd4);
        n = 0; while (!bus.res_valid && n < 100) begin step(); n++; end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_err, bus.req_ready, busy}
                !== {1'b1, ref_prod(25'd11, 25'd13), 2'd0, 1'b0, 4'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got vld=%b data=%h id=%0d err=%b rdy=%b busy=%b expected 1 %h 0 0 0000 1",
                         c, bus.res_valid, bus.res_data, bus.res_id, bus.res_err, bus.req_ready, busy,
                         ref_prod(25'd11, 25'd13));
            end
            step();
        end
        bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
        vectors++; if ({bus.res_valid, bus.req_ready} !== {1'b0, 4'b0}) begin
            miscompares++; $display("FAIL bp_no_same_cycle: got vld=%b rdy=%b expected 0 0000", bus.res_valid, bus.req_ready); end
        step();
        vectors++; if ({bus.req_ready, mul_x, mul_y} !== {4'b0010, 25'd21, 25'd4}) begin
            miscompares++; $display("FAIL bp_grant1: got rdy=%b x=%0d y=%0d expected 0010 21 4", bus.req_ready, mul_x, mul_y); end
        bus.req_valid[1] = 1'b0;
        n = 0; while (!bus.res_valid && n < 100) begin step(); n++; end
        vectors++; if ({bus.res_data, bus.res_id} !== {48'd84, 2'd1}) begin
            miscompares++; $display("FAIL bp_result1: got data=%h id=%0d expected 84 1", bus.res_data, bus.res_id); end
        bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
        exp_ptr = 2;
    endtask

    task automatic test_reset_mid();
        int n, acc, lat, rl; bit bad; logic [47:0] d; logic [IDW-1:0] rid; logic e; logic [N-1:0] rn; logic [1:0] post;
        set_req(2, 25'd100, 25'd200);
        n = 0; while (bus.req_ready == '0 && n < 60) begin step(); n++; end
        bus.req_valid[2] = 1'b0;
        repeat (5) step();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        vectors++;
        if ({bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_err, busy, mul_rst, mul_x, mul_y}
            !== {4'b0, 1'b0, 48'b0, 2'b0, 1'b0, 1'b0, 1'b1, 25'b0, 25'b0}) begin
            miscompares++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b data=%h id=%0d err=%b busy=%b mrst=%b x=%h y=%h",
                     bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, bus.res_err, busy, mul_rst, mul_x, mul_y);
        end
        bad = 1'b0;
        repeat (30) begin step(); if (bus.res_valid || !mul_rst || busy) bad = 1'b1; end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL midrun_no_result: got activity=1 expected 0"); end
        exp_ptr = 0;
        set_req(0, 25'd1, 25'd2);
        set_req(3, 25'd5, 25'd6);
        n = 0; while (bus.req_ready == '0 && n < 60) begin step(); n++; end
        vectors++; if (bus.req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL midrun_ptr_cleared: got %b expected 0001", bus.req_ready); end
        bus.req_valid[0] = 1'b0;
        n = 0; while (!bus.res_valid && n < 100) begin step(); n++; end
        bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
        run_op(-1, '0, '0, 1'b1, 0, acc, lat, rl, d, rid, e, rn, post);
        vectors++; if ({acc, d} !== {32'd3, 48'd30}) begin
            miscompares++; $display("FAIL midrun_next: got grant=%0d data=%h expected 3 1e", acc, d); end
        exp_ptr = 0;
    endtask

    task automatic test_random();
        bit pend[N];
        logic [24:0] px[N], py[N];
        logic [N-1:0] mask;
        int g, acc, lat, rl, exp_lat; logic [47:0] d, exp_d; logic [IDW-1:0] rid; logic e, exp_e;
        logic [N-1:0] rn; logic [1:0] post;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1; px[i] = 25'($urandom()); py[i] = 25'($urandom());
                    set_req(i, px[i], py[i]);
                end
            end
            mask = '0;
            for (int i = 0; i < N; i++) mask[i] = pend[i];
            if (mask == '0) begin
                g = int'($urandom_range(0, N - 1));
                pend[g] = 1'b1; px[g] = 25'($urandom()); py[g] = 25'($urandom());
                set_req(g, px[g], py[g]);
                mask[g] = 1'b1;
            end
            m_lat = int'($urandom_range(1, 36));
            g = exp_grant(mask, exp_ptr);
            exp_e   = (m_lat >= TMO);
            exp_d   = exp_e ? 48'd0 : ref_prod(px[g], py[g]);
            exp_lat = exp_e ? TMO : m_lat + 1;
            run_op(-1, '0, '0, 1'b1, int'($urandom_range(0, 3)), acc, lat, rl, d, rid, e, rn, post);
            vectors++;
            if (acc !== g || d !== exp_d || e !== exp_e || rid !== IDW'(g) || lat !== exp_lat) begin
                miscompares++;
                $display("FAIL random[%0d]: got grant=%0d data=%h err=%b id=%0d lat=%0d expected %0d %h %b %0d %0d",
                         r, acc, d, e, rid, lat, g, exp_d, exp_e, g, exp_lat);
            end
            pend[g] = 1'b0;
            exp_ptr = (g + 1) % N;
        end
        bus.req_valid = '0;
        m_lat = 14;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_rr_order();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
